// File: rtl/sw_score_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sw_score_collector_pkg
// Brief    : Shared widths and FSM encoding for the score collector.
// Revision : 1.0 - initial release
// ============================================================================
package sw_score_collector_pkg;

   localparam int SC_DATA_WIDTH   = 16;
   localparam int SC_ARRAY_LENGTH = 64;
   localparam int SC_ROW_WIDTH    = 11;
   localparam int SC_COL_WIDTH    = 7;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_COLLECT = 2'd1;
   localparam state_t ST_REPORT  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sw_score_collector_cmp.sv
`default_nettype none
// ============================================================================
// Module   : sm_greater
// Brief    : Strict sign-magnitude greater-than; +0 and -0 compare equal.
// Revision : 1.0 - initial release
// ============================================================================
module sm_greater #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt
);

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-2:0] a_mag;
   logic [WIDTH-2:0] b_mag;

   assign a_neg = a[WIDTH-1];
   assign b_neg = b[WIDTH-1];
   assign a_mag = a[WIDTH-2:0];
   assign b_mag = b[WIDTH-2:0];

   always_comb begin
      gt = 1'b0;
      if (!a_neg && b_neg) begin
         // positive beats negative unless both are a signed zero
         gt = (a_mag != '0) || (b_mag != '0);
      end else if (!a_neg && !b_neg) begin
         gt = a_mag > b_mag;
      end else if (a_neg && b_neg) begin
         gt = a_mag < b_mag;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sw_score_collector.sv
`default_nettype none
// ============================================================================
// Module   : sw_score_collector
// Brief    : Tracks the first-occurring maximum cell score of an alignment
//            and reports it over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sw_score_collector
   import sw_score_collector_pkg::*;
#(
   parameter int DATA_WIDTH = SC_DATA_WIDTH,
   parameter int ROW_WIDTH  = SC_ROW_WIDTH,
   parameter int COL_WIDTH  = SC_COL_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_start,
   input  logic                          i_valid,
   input  logic [DATA_WIDTH-1:0]         i_score,
   input  logic                          i_row_end,
   input  logic                          i_last,
   output logic                          o_busy,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [DATA_WIDTH-1:0]         o_max,
   output logic [ROW_WIDTH-1:0]          o_row,
   output logic [COL_WIDTH-1:0]          o_col,
   output logic [ROW_WIDTH+COL_WIDTH-1:0] o_cells
);

   state_t               state;
   state_t               state_nxt;
   logic [ROW_WIDTH-1:0] row_cnt;
   logic [COL_WIDTH-1:0] col_cnt;
   logic                 accept;
   logic                 greater;

   assign accept = (state == ST_COLLECT) && i_valid;

   sm_greater #(
      .WIDTH (DATA_WIDTH)
   ) u_cmp (
      .a  (i_score),
      .b  (o_max),
      .gt (greater)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (i_start)             state_nxt = ST_COLLECT;
         ST_COLLECT: if (i_valid && i_last)   state_nxt = ST_REPORT;
         ST_REPORT:  if (i_ready)             state_nxt = ST_IDLE;
         default:                             state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy  = (state == ST_COLLECT) || (state == ST_REPORT);
      o_valid = (state == ST_REPORT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_max   <= '0;
         o_row   <= '0;
         o_col   <= '0;
         o_cells <= '0;
         row_cnt <= '0;
         col_cnt <= '0;
      end else if ((state == ST_IDLE) && i_start) begin
         o_max   <= '0;
         o_row   <= '0;
         o_col   <= '0;
         o_cells <= '0;
         row_cnt <= '0;
         col_cnt <= '0;
      end else if (accept) begin
         if (o_cells != '1) begin
            o_cells <= o_cells + 1'b1;
         end
         // strict compare keeps the earliest cell on ties
         if (greater) begin
            o_max <= i_score;
            o_row <= row_cnt;
            o_col <= col_cnt;
         end
         if (i_row_end) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + 1'b1;
         end else begin
            col_cnt <= col_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/sw_score_collector.md
Name: sw_score_collector

Overview:
- Downstream stage of the Smith-Waterman systolic array. Consumes the stream of cell scores V from the array's PE outputs.
- Tracks the global maximum score and the (row, column) cell where it first occurred.
- Presents the final result through a valid/ready handshake to the host/result-SRAM writer.
- Score comparison uses the shared sign-magnitude max semantics (myMax); it sits alongside myMax/myMax4 in the scoring datapath.

Parameters:
- DATA_WIDTH, `V_E_F_Bit (16): score width; sign-magnitude, MSB = sign.
- ROW_WIDTH, 11: row (reference position) index width.
- COL_WIDTH, 7: column (query position) index width; covers `ARRAY_LENGTH = 64 with headroom.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle pulse that begins a new alignment; accepted only in IDLE.
- i_valid  in  1  i_score is a valid cell score this cycle.
- i_score  in  DATA_WIDTH  cell score V (sign-magnitude).
- i_row_end  in  1  qualifies i_valid: this cell is the last column of the current row.
- i_last  in  1  qualifies i_valid: this cell is the final cell of the matrix.
- o_busy  out  1  high in COLLECT and REPORT.
- o_valid  out  1  result valid (REPORT).
- i_ready  in  1  consumer accepts the result.
- o_max  out  DATA_WIDTH  best score.
- o_row  out  ROW_WIDTH  row of best score.
- o_col  out  COL_WIDTH  column of best score.
- o_cells  out  ROW_WIDTH+COL_WIDTH  number of cells consumed.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - o_busy=0, o_valid=0.
  - o_max=0 (positive zero), o_row=0, o_col=0, o_cells=0.
  - Row/column counters cleared.
  - Reset mid-COLLECT or mid-REPORT aborts; no result is emitted.
- FSM states: IDLE, COLLECT, REPORT.
  - IDLE -> COLLECT on i_start. The same edge clears max/row/col/cells and counters. i_valid in the same cycle as i_start is ignored.
  - COLLECT: on each i_valid cycle:
    - cells += 1.
    - Compare i_score against the running max. Replace max, row, col only when i_score is strictly greater under sign-magnitude order. Ties keep the earliest cell.
    - Ordering: positive > negative. Among positives, larger magnitude wins. Among negatives, smaller magnitude wins. +0 and -0 compare equal, so no update.
    - Counters: col += 1. If i_row_end, col wraps to 0 and row += 1.
    - If i_last: transition to REPORT next cycle. The i_last cell itself is included in the max.
  - i_valid=0 in COLLECT: hold all state.
  - i_start in COLLECT or REPORT: ignored.
  - REPORT: o_valid=1 and outputs stable.
    - o_valid & i_ready -> IDLE on the next edge. o_valid drops; result registers hold their values until the next i_start.
    - i_valid in REPORT or IDLE is ignored.
- Latency:
  - Result registers update on the edge after the qualifying i_valid.
  - o_valid asserts on the edge after the i_last cell.
  - If i_ready is already high, o_valid is high for exactly 1 cycle.
- Width and overflow rules:
  - Column counter overflow (col reaches 2^COL_WIDTH-1 without i_row_end) wraps modulo. Upstream guarantees i_row_end.
  - Row counter wraps modulo 2^ROW_WIDTH.
  - The cells counter saturates at all-ones.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared header (the existing util include):
  - `V_E_F_Bit and `ARRAY_LENGTH.
  - New defines for row/column widths.
  - FSM state encoding localparams: IDLE=2'd0, COLLECT=2'd1, REPORT=2'd2.
- Sub-module: reuse myMax for the compare datapath.
  - Add sm_greater (strict sign-magnitude greater-than, 1-bit output) as a sibling in the same file. The collector needs strict-greater for first-occurrence tie-breaking, which myMax's >= selection cannot provide.

Test Plan:
- Basic: start, then a 2x3 stream with scores 3,7,5 / 2,7,9 (i_row_end on 3rd and 6th, i_last on 6th), i_ready=1 -> one-cycle o_valid, o_max=9, o_row=1, o_col=2, o_cells=6.
- Tie: scores 4,8,8,1 in a single row (i_last on 4th) -> o_max=8, o_col=1, o_row=0.
- Sign-magnitude: scores -5 (16'h8005), -2 (16'h8002), +0 -> max stays +0, o_row=0, o_col=0. A lone stream of 16'h8003 then 16'h8001 -> still +0, no update.
- Back-pressure and gaps: i_valid deasserted on alternate cycles, i_ready held low 5 cycles after i_last -> o_valid held 5+ cycles with stable outputs; clears 1 cycle after i_ready.
- Reset mid-run: assert rst after 3 cells of COLLECT -> immediate o_busy=0, o_max=0, o_cells=0. A subsequent i_start and full stream produces a correct result.
- Ignored inputs: i_start pulsed during COLLECT, i_valid during IDLE/REPORT -> no state change, counters unchanged.
